// File: rtl/pre_processor_if.sv
// pre_processor_if: upstream/downstream handshake, rounding mode and decoded binary32 operand bus
interface pre_processor_if;
    logic        valid_in, ready_out, valid_out, ready_in;
    logic [2:0]  rm_in, rm_out;
    logic [31:0] a_in, b_in, c_in;
    logic        a_sgn, b_sgn, c_sgn;
    logic [9:0]  a_exp, b_exp, c_exp;
    logic [23:0] a_man, b_man, c_man;
    logic        a_zero, a_inf, a_snan, a_qnan, a_denorm;
    logic        b_zero, b_inf, b_snan, b_qnan, b_denorm;
    logic        c_zero, c_inf, c_snan, c_qnan, c_denorm;
    logic        IV_snan;
    modport master (
        output valid_in, ready_in, rm_in, a_in, b_in, c_in,
        input  ready_out, valid_out, rm_out,
        input  a_sgn, b_sgn, c_sgn, a_exp, b_exp, c_exp, a_man, b_man, c_man,
        input  a_zero, a_inf, a_snan, a_qnan, a_denorm,
        input  b_zero, b_inf, b_snan, b_qnan, b_denorm,
        input  c_zero, c_inf, c_snan, c_qnan, c_denorm, IV_snan
    );
    modport slave (
        input  valid_in, ready_in, rm_in, a_in, b_in, c_in,
        output ready_out, valid_out, rm_out,
        output a_sgn, b_sgn, c_sgn, a_exp, b_exp, c_exp, a_man, b_man, c_man,
        output a_zero, a_inf, a_snan, a_qnan, a_denorm,
        output b_zero, b_inf, b_snan, b_qnan, b_denorm,
        output c_zero, c_inf, c_snan, c_qnan, c_denorm, IV_snan
    );
endinterface

// File: rtl/pre_processor.sv
// pre_processor: single-stage binary32 unpack/classify for three operands with valid/ready handshake.
// Define FPU_PRE_DENORM_NORM_EN to normalize denormals; otherwise denormals are flushed to zero (DAZ).
module pre_processor (
    input logic clk,
    input logic reset,
    input logic flush,
    pre_processor_if.slave io
);
    typedef struct packed {
        logic        sgn;
        logic [9:0]  exp;
        logic [23:0] man;
        logic        zero, inf, snan, qnan, denorm;
    } op_t;

    function automatic op_t decode(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] f;
        op_t         r;
`ifdef FPU_PRE_DENORM_NORM_EN
        logic [4:0]  lz;
`endif
        e = x[30:23];
        f = x[22:0];
        r = '0;
        r.sgn = x[31];
        if (e == 8'hff) begin
            r.exp  = 10'd128;
            r.man  = {1'b1, f};
            r.inf  = f == 23'd0;
            r.qnan = f != 23'd0 && f[22];
            r.snan = f != 23'd0 && !f[22];
        end else if (e != 8'd0) begin
            r.exp = {2'b00, e} - 10'd127;
            r.man = {1'b1, f};
        end else if (f == 23'd0) begin
            r.zero = 1'b1;
        end else begin
`ifdef FPU_PRE_DENORM_NORM_EN
            // highest set bit wins: leading zeros of {1'b0,f} is 23 minus its position
            lz = 5'd23;
            for (int i = 0; i < 23; i++)
                if (f[i]) lz = 5'(23 - i);
            r.denorm = 1'b1;
            r.man    = {1'b0, f} << lz;
            r.exp    = 10'h382 - {5'd0, lz};
`else
            r.zero   = 1'b1;
            r.denorm = 1'b1;
`endif
        end
        return r;
    endfunction

    op_t        da, db, dc, a_q, b_q, c_q;
    logic       valid_q, iv_q, ready;
    logic [2:0] rm_q;

    always_comb begin
        da = decode(io.a_in);
        db = decode(io.b_in);
        dc = decode(io.c_in);
    end

    assign ready = io.ready_in || !valid_q;

    // an idle or drained stage reads as all-zero, so clearing whenever ready covers both
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            valid_q <= 1'b0;
            rm_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            iv_q    <= 1'b0;
        end else if (io.valid_in && ready) begin
            valid_q <= 1'b1;
            rm_q    <= io.rm_in;
            a_q     <= da;
            b_q     <= db;
            c_q     <= dc;
            iv_q    <= da.snan | db.snan | dc.snan;
        end else if (ready) begin
            valid_q <= 1'b0;
            rm_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            iv_q    <= 1'b0;
        end
    end

    assign io.ready_out = ready;
    assign io.valid_out = valid_q;
    assign io.rm_out    = rm_q;
    assign io.IV_snan   = iv_q;
    assign io.a_sgn     = a_q.sgn;
    assign io.a_exp     = a_q.exp;
    assign io.a_man     = a_q.man;
    assign io.a_zero    = a_q.zero;
    assign io.a_inf     = a_q.inf;
    assign io.a_snan    = a_q.snan;
    assign io.a_qnan    = a_q.qnan;
    assign io.a_denorm  = a_q.denorm;
    assign io.b_sgn     = b_q.sgn;
    assign io.b_exp     = b_q.exp;
    assign io.b_man     = b_q.man;
    assign io.b_zero    = b_q.zero;
    assign io.b_inf     = b_q.inf;
    assign io.b_snan    = b_q.snan;
    assign io.b_qnan    = b_q.qnan;
    assign io.b_denorm  = b_q.denorm;
    assign io.c_sgn     = c_q.sgn;
    assign io.c_exp     = c_q.exp;
    assign io.c_man     = c_q.man;
    assign io.c_zero    = c_q.zero;
    assign io.c_inf     = c_q.inf;
    assign io.c_snan    = c_q.snan;
    assign io.c_qnan    = c_q.qnan;
    assign io.c_denorm  = c_q.denorm;
endmodule
